fmult_accum_seq: RTL and testbench
==================================

// Module: fmult_accum_seq
// PURPOSE
// - G.726 ADPCM predictor: eight FMULT products (6 zero-section, 2 pole-section) on ONE shared multiplier, then ACCUM.
// - Produces signal estimate SE and zero-section estimate SEZ for one channel per start request.
// - Sits between the adaptive predictor coefficient update and the reconstruction/quantizer path in the single-resource MCAC datapath.
// PARAMETERS
// - none; all widths fixed by G.726.
// PORTS
// - clk          in   1   rising-edge clock (only clock)
// - reset        in   1   asynchronous, active-low reset
// - start        in   1   1-cycle request; all operand inputs are sampled on the same edge
// - b1..b6       in   16  zero-section coefficients, two's complement
// - a1,a2        in   16  pole-section coefficients, two's complement
// - dq1..dq6     in   11  past quantized differences, float {S[10],EXP[9:6],MANT[5:0]}
// - sr1,sr2      in   11  past reconstructed signals, same float format
// - sez          out  15  zero-section estimate, registered
// - se           out  15  signal estimate, registered
// - done         out  1   one-cycle pulse: sez/se updated
// - scan_in0..4  in   1   scan chain inputs; functionally unused
// - scan_enable  in   1   scan shift enable; functionally unused
// - test_mode    in   1   DFT mode; functionally unused
// - scan_out0..4 out  1   scan chain outputs; driven 0 in RTL, replaced by DFT insertion
// BEHAVIOUR
// - Reset: state=IDLE, done=0, sez=0, se=0, accumulator=0, counter=0.
// - FSM IDLE -> CALC when start=1: latch all 16 operands, clear accumulator, cnt=0.
// - CALC: on each of 8 edges, accumulate one product in order (b1,dq1)..(b6,dq6), (a1,sr1), (a2,sr2).
// - SEZI is snapshotted after the 6th product.
// - On the 8th CALC edge: go to DONE, sez<=SEZI[15:1], se<=SEI[15:1], done<=1.
// - Latency: done is high in the 8th cycle after the start edge. DONE -> IDLE next edge, done<=0.
// - sez/se hold their values until the next completion.
// - start is ignored outside IDLE (including the DONE cycle); no queueing.
// - Reset asserted mid-CALC aborts immediately: no done, outputs return to 0.
// - FMULT(An,Srn):
//   - AnS=An[15]; AnMAG = AnS ? ((-An)>>2)&0x1FFF : An>>2 (13b).
//   - AnEXP = index of MSB of AnMAG plus 1 (0..13; 0 when AnMAG=0).
//   - AnMANT = AnMAG==0 ? 32 : ({AnMAG,6'b0} >> AnEXP) (6b).
//   - WS = AnS ^ SrnS; WEXP = AnEXP + SrnEXP (5b); WMANT = (AnMANT*SrnMANT + 48) >> 4 (8b).
//   - WMAG = WEXP<=26 ? ({WMANT,7'b0} >> (26-WEXP)) : ({WMANT,7'b0} << (WEXP-26)) & 0x7FFF.
//   - W = WS ? -WMAG : WMAG (16b, modulo 2^16).
// - ACCUM: all sums are 16-bit modulo 2^16; no saturation.
//   - SEZI = WB1+..+WB6; SEI = SEZI + WA1 + WA2.
// STRUCTURE
// - Shared package g726_pkg holds:
//   - float-operand typedef (struct S/EXP/MANT)
//   - widths (COEF_W=16, FLT_W=11, EST_W=15)
//   - product count constant NPROD=8, zero-section count NZ=6
// - One combinational sub-module: g726_fmult (An, Srn -> 16b W).
//   - Instantiated exactly once.
//   - Operands selected by a mux on cnt.
// - Top holds FSM, counter, accumulator, output registers.
// TESTING
// - Zero vector: all coefs 0, all dq/sr = 11'h020 -> sez=15'h0000, se=15'h0000; done one cycle after 8 CALC cycles.
// - a1=16'h4000, sr1=11'h2A0, others zero/11'h020 -> WA1=1072, se=15'h0218, sez=15'h0000.
// - a1=16'hC000, sr1=11'h2A0 -> WA1=16'hFBD0, se=15'h7DE8, sez=15'h0000.
// - b1=16'h4000, dq1=11'h2A0, rest zero -> sez=15'h0218, se=15'h0218.
// - start re-pulsed during CALC -> ignored, single done.
//   - reset low mid-CALC -> done never pulses, sez=se=0.
//   - next start after reset completes normally.
// - Random operands vs C golden model of G.726 FMULT/ACCUM; also check scan_out0..4 stay 0.

Source files
------------

// File: rtl/g726_pkg.sv
// Shared widths, float operand layout and FSM encoding for the G.726 predictor datapath.
package g726_pkg;

    localparam int COEF_W = 16;
    localparam int FLT_W  = 11;
    localparam int EST_W  = 15;
    localparam int NPROD  = 8;
    localparam int NZ     = 6;

    typedef struct packed {
        logic       s;
        logic [3:0] exp;
        logic [5:0] mant;
    } flt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Position of the most significant set bit plus one; 0 for a zero magnitude.
    function automatic logic [3:0] msb_exp(input logic [12:0] mag);
        logic [3:0] e;
        e = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (mag[i]) e = 4'(i + 1);
        end
        return e;
    endfunction

endpackage

// File: rtl/g726_fmult.sv
// Combinational G.726 FMULT: coefficient times float operand, 16-bit two's complement result.
module g726_fmult
    import g726_pkg::*;
(
    input  logic [COEF_W-1:0] an,
    input  flt_t              srn,
    output logic [COEF_W-1:0] w
);

    logic        an_s;
    logic [15:0] an_neg;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [18:0] an_norm;
    logic [5:0]  an_mant;
    logic        w_s;
    logic [4:0]  w_exp;
    logic [11:0] prod;
    logic [7:0]  w_mant;
    logic [14:0] w_base;
    logic [14:0] w_mag;
    logic [24:0] unused_bits;

    always_comb begin
        an_s    = an[15];
        an_neg  = -an;
        an_mag  = an_s ? an_neg[14:2] : an[14:2];
        an_exp  = msb_exp(an_mag);
        an_norm = {an_mag, 6'b0} >> an_exp;
        an_mant = (an_mag == 13'd0) ? 6'd32 : an_norm[5:0];
        w_s     = an_s ^ srn.s;
        w_exp   = {1'b0, an_exp} + {1'b0, srn.exp};
        prod    = {6'b0, an_mant} * {6'b0, srn.mant} + 12'd48;
        w_mant  = prod[11:4];
        w_base  = {w_mant, 7'b0};
        // Left shift drops bits above 15, giving the 0x7FFF wrap for large exponents.
        if (w_exp <= 5'd26) w_mag = w_base >> (5'd26 - w_exp);
        else                w_mag = w_base << (w_exp - 5'd26);
        w = w_s ? -{1'b0, w_mag} : {1'b0, w_mag};
    end

    assign unused_bits = {an[1:0], an_neg[15], an_neg[1:0], an_norm[18:6], prod[3:0], 3'b0};

endmodule

// File: rtl/fmult_accum_seq.sv
// Sequential G.726 predictor: eight FMULT products through one multiplier, accumulated into SEZ/SE.
module fmult_accum_seq
    import g726_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [COEF_W-1:0] b1, b2, b3, b4, b5, b6,
    input  logic [COEF_W-1:0] a1, a2,
    input  logic [FLT_W-1:0]  dq1, dq2, dq3, dq4, dq5, dq6,
    input  logic [FLT_W-1:0]  sr1, sr2,
    output logic [EST_W-1:0]  sez,
    output logic [EST_W-1:0]  se,
    output logic              done,
    input  logic              scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0, scan_out1, scan_out2, scan_out3, scan_out4
);

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    logic [COEF_W-1:0] acc, sezi, sum, w, op_a;
    flt_t              op_s;
    logic [COEF_W-1:0] b_r [NZ];
    logic [COEF_W-1:0] a_r [2];
    flt_t              dq_r [NZ];
    flt_t              sr_r [2];
    logic              unused_scan;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 3'(NPROD - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-section pairs first, then the two pole-section pairs.
    always_comb begin
        op_a = b_r[0];
        op_s = dq_r[0];
        case (cnt)
            3'd0: begin op_a = b_r[0]; op_s = dq_r[0]; end
            3'd1: begin op_a = b_r[1]; op_s = dq_r[1]; end
            3'd2: begin op_a = b_r[2]; op_s = dq_r[2]; end
            3'd3: begin op_a = b_r[3]; op_s = dq_r[3]; end
            3'd4: begin op_a = b_r[4]; op_s = dq_r[4]; end
            3'd5: begin op_a = b_r[5]; op_s = dq_r[5]; end
            3'd6: begin op_a = a_r[0]; op_s = sr_r[0]; end
            default: begin op_a = a_r[1]; op_s = sr_r[1]; end
        endcase
    end

    g726_fmult u_fmult (
        .an  (op_a),
        .srn (op_s),
        .w   (w)
    );

    assign sum = acc + w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            sez  <= '0;
            se   <= '0;
            acc  <= '0;
            sezi <= '0;
            cnt  <= '0;
            for (int i = 0; i < NZ; i++) begin
                b_r[i]  <= '0;
                dq_r[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                a_r[i]  <= '0;
                sr_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        b_r[0] <= b1; b_r[1] <= b2; b_r[2] <= b3;
                        b_r[3] <= b4; b_r[4] <= b5; b_r[5] <= b6;
                        a_r[0] <= a1; a_r[1] <= a2;
                        dq_r[0] <= dq1; dq_r[1] <= dq2; dq_r[2] <= dq3;
                        dq_r[3] <= dq4; dq_r[4] <= dq5; dq_r[5] <= dq6;
                        sr_r[0] <= sr1; sr_r[1] <= sr2;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= sum;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(NZ - 1)) sezi <= sum;
                    if (cnt == 3'(NPROD - 1)) begin
                        sez  <= sezi[15:1];
                        se   <= sum[15:1];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode, sezi[0]};

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Directed and model-checked bench for the shared-multiplier G.726 FMULT/ACCUM sequencer.
module tb_fmult_accum_seq;

    typedef struct packed {
        logic [5:0][15:0] b;
        logic [1:0][15:0] a;
        logic [5:0][10:0] dq;
        logic [1:0][10:0] sr;
        logic [14:0]      sez;
        logic [14:0]      se;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2;
    logic [10:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;
    logic [14:0] sez, se;
    logic        done;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    fmult_accum_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
        .a1(a1), .a2(a2),
        .dq1(dq1), .dq2(dq2), .dq3(dq3), .dq4(dq4), .dq5(dq5), .dq6(dq6),
        .sr1(sr1), .sr2(sr2),
        .sez(sez), .se(se), .done(done),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden FMULT written directly from the G.726 arithmetic in integers.
    function automatic int model_fmult(input logic [15:0] an, input logic [10:0] srn);
        int mag, e, mant, wexp, wmant, wmag;
        if (an[15]) mag = (((65536 - int'(an)) & 'hFFFF) >> 2) & 'h1FFF;
        else        mag = int'(an) >> 2;
        e = 0;
        for (int i = 0; i < 13; i++) if (mag >= (1 << i)) e = i + 1;
        mant  = (mag == 0) ? 32 : (((mag * 64) >> e) & 63);
        wexp  = e + int'(srn[9:6]);
        wmant = (mant * int'(srn[5:0]) + 48) >> 4;
        if (wexp <= 26) wmag = (wmant * 128) >> (26 - wexp);
        else            wmag = ((wmant * 128) << (wexp - 26)) & 'h7FFF;
        return (an[15] ^ srn[10]) ? ((65536 - wmag) & 'hFFFF) : wmag;
    endfunction

    function automatic vec_t model_vec(input vec_t v);
        vec_t r;
        int   sezi, sei;
        r = v;
        sezi = 0;
        for (int i = 0; i < 6; i++) sezi = (sezi + model_fmult(v.b[i], v.dq[i])) & 'hFFFF;
        sei = sezi;
        for (int i = 0; i < 2; i++) sei = (sei + model_fmult(v.a[i], v.sr[i])) & 'hFFFF;
        r.sez = 15'(sezi >> 1);
        r.se  = 15'(sei >> 1);
        return r;
    endfunction

    function automatic vec_t base_vec();
        vec_t v;
        v = '0;
        for (int i = 0; i < 6; i++) v.dq[i] = 11'h020;
        for (int i = 0; i < 2; i++) v.sr[i] = 11'h020;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        b1 = v.b[0]; b2 = v.b[1]; b3 = v.b[2]; b4 = v.b[3]; b5 = v.b[4]; b6 = v.b[5];
        a1 = v.a[0]; a2 = v.a[1];
        dq1 = v.dq[0]; dq2 = v.dq[1]; dq3 = v.dq[2]; dq4 = v.dq[3]; dq5 = v.dq[4]; dq6 = v.dq[5];
        sr1 = v.sr[0]; sr2 = v.sr[1];
        {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode} = 7'($urandom);
    endtask

    // Starts one computation; optionally re-pulses start with other operands at negedge number repulse_at.
    task automatic run_vec(input vec_t v, input vec_t alt, input int repulse_at, input string tag);
        int lat, ndone, scan_hits;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; ndone = 0; scan_hits = 0;
        for (int i = 1; i <= 22; i++) begin
            if (done) begin
                ndone++;
                if (lat == 0) lat = i;
            end
            if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) scan_hits++;
            if (i == repulse_at) begin
                drive(alt);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        // done rises on the 8th edge after the start edge, seen at the 9th sampling negedge
        check({tag, " latency"}, lat, 9);
        check({tag, " done_count"}, ndone, 1);
        check({tag, " sez"}, {17'b0, sez}, {17'b0, v.sez});
        check({tag, " se"}, {17'b0, se}, {17'b0, v.se});
        check({tag, " scan_out"}, scan_hits, 0);
    endtask

    initial begin
        vec_t v, none;
        int   ndone;

        reset = 1'b0;
        start = 1'b0;
        none  = base_vec();
        drive(none);

        vecs[0] = base_vec(); vecs[0].sez = 15'h0000; vecs[0].se = 15'h0000;
        vecs[1] = base_vec(); vecs[1].a[0] = 16'h4000; vecs[1].sr[0] = 11'h2A0;
        vecs[1].sez = 15'h0000; vecs[1].se = 15'h0218;
        vecs[2] = base_vec(); vecs[2].a[0] = 16'hC000; vecs[2].sr[0] = 11'h2A0;
        vecs[2].sez = 15'h0000; vecs[2].se = 15'h7DE8;
        vecs[3] = base_vec(); vecs[3].b[0] = 16'h4000; vecs[3].dq[0] = 11'h2A0;
        vecs[3].sez = 15'h0218; vecs[3].se = 15'h0218;
        vecs[4] = vecs[3]; vecs[4].a[0] = 16'hC000; vecs[4].sr[0] = 11'h2A0;
        vecs[4].sez = 15'h0218; vecs[4].se = 15'h0000;
        vecs[5] = base_vec(); vecs[5].b[1] = 16'h4000; vecs[5].dq[1] = 11'h6A0;
        vecs[5].sez = 15'h7DE8; vecs[5].se = 15'h7DE8;
        vecs[6] = base_vec(); vecs[6].a[1] = 16'h2000; vecs[6].sr[1] = 11'h2A0;
        vecs[6].sez = 15'h0000; vecs[6].se = 15'h010C;
        vecs[7] = base_vec(); vecs[7].a[0] = 16'h7FFC; vecs[7].sr[0] = 11'h3FF;
        vecs[7].sez = 15'h0000; vecs[7].se = 15'h3B00;
        vecs[8] = base_vec(); vecs[8].a[0] = 16'h8000; vecs[8].sr[0] = 11'h3FF;
        vecs[8].sez = 15'h0000; vecs[8].se = 15'h7FFC;
        vecs[9] = base_vec(); vecs[9].b[5] = 16'h4000; vecs[9].dq[5] = 11'h2A0;
        vecs[9].a[0] = 16'h4000; vecs[9].sr[0] = 11'h2A0;
        vecs[9].sez = 15'h0218; vecs[9].se = 15'h0430;

        repeat (3) @(negedge clk);
        check("reset done", done, 0);
        check("reset sez", sez, 0);
        check("reset se", se, 0);
        check("reset scan_out", {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], none, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v = '0;
            for (int k = 0; k < 6; k++) begin
                v.b[k]  = 16'($urandom);
                v.dq[k] = 11'($urandom);
            end
            for (int k = 0; k < 2; k++) begin
                v.a[k]  = 16'($urandom);
                v.sr[k] = 11'($urandom);
            end
            run_vec(model_vec(v), none, 0, $sformatf("rand%0d", i));
        end

        // start during CALC and during the DONE cycle must both be ignored
        run_vec(vecs[3], vecs[1], 3, "repulse_calc");
        run_vec(vecs[6], vecs[2], 9, "repulse_done");

        // reset mid-CALC after a nonzero result is already held
        @(negedge clk);
        drive(vecs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset sez", sez, 0);
        check("midreset se", se, 0);
        check("midreset done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset no_done", ndone, 0);
        check("midreset hold sez", sez, 0);
        check("midreset hold se", se, 0);
        run_vec(vecs[1], none, 0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
